// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded instruction in, registered EX view, stall and perf counters out.
// The stage binds to the slave modport; the driving side (decode/bench) uses master.
interface id_ex_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid_i;
  logic             id_branch_i;
  logic             id_memread_i;
  logic             id_memtoreg_i;
  logic             id_memwrite_i;
  logic             id_alusrc_i;
  logic             id_regwrite_i;
  logic [3:0]       id_aluop_i;
  logic [XLEN-1:0]  id_pc_i;
  logic [XLEN-1:0]  id_rs1_data_i;
  logic [XLEN-1:0]  id_rs2_data_i;
  logic [XLEN-1:0]  id_imm_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic [4:0]       id_rd_i;
  logic             id_uses_rs1_i;
  logic             id_uses_rs2_i;
  logic             flush_i;
  logic             ex_hold_i;

  logic             ex_valid_o;
  logic             ex_branch_o;
  logic             ex_memread_o;
  logic             ex_memtoreg_o;
  logic             ex_memwrite_o;
  logic             ex_alusrc_o;
  logic             ex_regwrite_o;
  logic [3:0]       ex_aluop_o;
  logic [XLEN-1:0]  ex_pc_o;
  logic [XLEN-1:0]  ex_rs1_data_o;
  logic [XLEN-1:0]  ex_rs2_data_o;
  logic [XLEN-1:0]  ex_imm_o;
  logic [4:0]       ex_rs1_o;
  logic [4:0]       ex_rs2_o;
  logic [4:0]       ex_rd_o;
  logic             id_stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport slave (
    input  id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i, id_alusrc_i,
           id_regwrite_i, id_aluop_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i, flush_i, ex_hold_i,
    output ex_valid_o, ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o, ex_alusrc_o,
           ex_regwrite_o, ex_aluop_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, id_stall_o, bubble_cnt_o, flush_cnt_o
  );

  modport master (
    output id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i, id_alusrc_i,
           id_regwrite_i, id_aluop_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i, flush_i, ex_hold_i,
    input  ex_valid_o, ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o, ex_alusrc_o,
           ex_regwrite_o, ex_aluop_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, id_stall_o, bubble_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, EX hold and
// saturating bubble/flush performance counters.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic            memread;
    logic            memtoreg;
    logic            memwrite;
    logic            alusrc;
    logic            regwrite;
    logic [3:0]      aluop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_t;

  ex_t              ex_q, ex_d, id_pkt;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             rs1_match, rs2_match;

  assign rs1_match = bus.id_uses_rs1_i && (bus.id_rs1_i == ex_q.rd);
  assign rs2_match = bus.id_uses_rs2_i && (bus.id_rs2_i == ex_q.rd);
  assign hz = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && (rs1_match || rs2_match) &&
              bus.id_valid_i;

  assign bus.id_stall_o = !bus.flush_i && (hz || bus.ex_hold_i);

  always_comb begin
    // A non-valid decode slot still loads, but with every control bit cleared.
    id_pkt          = '0;
    id_pkt.valid    = bus.id_valid_i;
    id_pkt.branch   = bus.id_valid_i & bus.id_branch_i;
    id_pkt.memread  = bus.id_valid_i & bus.id_memread_i;
    id_pkt.memtoreg = bus.id_valid_i & bus.id_memtoreg_i;
    id_pkt.memwrite = bus.id_valid_i & bus.id_memwrite_i;
    id_pkt.alusrc   = bus.id_valid_i & bus.id_alusrc_i;
    id_pkt.regwrite = bus.id_valid_i & bus.id_regwrite_i;
    id_pkt.aluop    = bus.id_valid_i ? bus.id_aluop_i : 4'd0;
    id_pkt.pc       = bus.id_pc_i;
    id_pkt.rs1_data = bus.id_rs1_data_i;
    id_pkt.rs2_data = bus.id_rs2_data_i;
    id_pkt.imm      = bus.id_imm_i;
    id_pkt.rs1      = bus.id_rs1_i;
    id_pkt.rs2      = bus.id_rs2_i;
    id_pkt.rd       = bus.id_rd_i;
  end

  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bus.flush_i) begin
      ex_d = '0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (bus.ex_hold_i) begin
      ex_d = ex_q;
    end else if (hz) begin
      ex_d = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.ex_valid_o    = ex_q.valid;
  assign bus.ex_branch_o   = ex_q.branch;
  assign bus.ex_memread_o  = ex_q.memread;
  assign bus.ex_memtoreg_o = ex_q.memtoreg;
  assign bus.ex_memwrite_o = ex_q.memwrite;
  assign bus.ex_alusrc_o   = ex_q.alusrc;
  assign bus.ex_regwrite_o = ex_q.regwrite;
  assign bus.ex_aluop_o    = ex_q.aluop;
  assign bus.ex_pc_o       = ex_q.pc;
  assign bus.ex_rs1_data_o = ex_q.rs1_data;
  assign bus.ex_rs2_data_o = ex_q.rs2_data;
  assign bus.ex_imm_o      = ex_q.imm;
  assign bus.ex_rs1_o      = ex_q.rs1;
  assign bus.ex_rs2_o      = ex_q.rs2;
  assign bus.ex_rd_o       = ex_q.rd;
  assign bus.bubble_cnt_o  = bubble_cnt_q;
  assign bus.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, plain load, load-use bubble, x0 and
// unused-operand non-hazards, flush priority, EX hold and counter saturation.
module tb_id_ex_stage;

  logic clk_i;
  logic rst_ni;
  int   pass_cnt;
  int   total_cnt;

  id_ex_if #(.XLEN(32), .CNT_W(16)) bus ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_id();
    bus.id_valid_i    = 1'b0;
    bus.id_branch_i   = 1'b0;
    bus.id_memread_i  = 1'b0;
    bus.id_memtoreg_i = 1'b0;
    bus.id_memwrite_i = 1'b0;
    bus.id_alusrc_i   = 1'b0;
    bus.id_regwrite_i = 1'b0;
    bus.id_aluop_i    = 4'd0;
    bus.id_pc_i       = 32'd0;
    bus.id_rs1_data_i = 32'd0;
    bus.id_rs2_data_i = 32'd0;
    bus.id_imm_i      = 32'd0;
    bus.id_rs1_i      = 5'd0;
    bus.id_rs2_i      = 5'd0;
    bus.id_rd_i       = 5'd0;
    bus.id_uses_rs1_i = 1'b0;
    bus.id_uses_rs2_i = 1'b0;
    bus.flush_i       = 1'b0;
    bus.ex_hold_i     = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  // Put a load word with destination rd into EX.
  task automatic load_lw(input logic [4:0] rd);
    clear_id();
    bus.id_valid_i    = 1'b1;
    bus.id_memread_i  = 1'b1;
    bus.id_memtoreg_i = 1'b1;
    bus.id_regwrite_i = 1'b1;
    bus.id_alusrc_i   = 1'b1;
    bus.id_rs1_i      = 5'd2;
    bus.id_uses_rs1_i = 1'b1;
    bus.id_rd_i       = rd;
    tick();
  endtask

  task automatic test_reset();
    clear_id();
    bus.id_valid_i    = 1'b1;
    bus.id_branch_i   = 1'b1;
    bus.id_memread_i  = 1'b1;
    bus.id_memtoreg_i = 1'b1;
    bus.id_memwrite_i = 1'b1;
    bus.id_alusrc_i   = 1'b1;
    bus.id_regwrite_i = 1'b1;
    bus.id_aluop_i    = 4'hA;
    bus.id_pc_i       = 32'hDEAD_BEEF;
    bus.id_rs1_data_i = 32'h1111_1111;
    bus.id_rs2_data_i = 32'h2222_2222;
    bus.id_imm_i      = 32'h3333_3333;
    bus.id_rs1_i      = 5'd1;
    bus.id_rs2_i      = 5'd2;
    bus.id_rd_i       = 5'd9;
    bus.id_uses_rs1_i = 1'b1;
    bus.id_uses_rs2_i = 1'b1;
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    tick();
    total_cnt++;
    if (bus.ex_pc_o !== 32'hDEAD_BEEF || bus.flush_cnt_o !== 16'd1)
      $display("FAIL reset_preload pc=%h flush_cnt=%0d required pc=deadbeef flush_cnt=1",
               bus.ex_pc_o, bus.flush_cnt_o);
    else pass_cnt++;
    #2;
    rst_ni = 1'b0;
    #1;
    total_cnt++;
    if ({bus.ex_valid_o, bus.ex_branch_o, bus.ex_memread_o, bus.ex_memtoreg_o,
         bus.ex_memwrite_o, bus.ex_alusrc_o, bus.ex_regwrite_o} !== 7'd0)
      $display("FAIL reset_ctrl got valid/ctrl=%b required 0000000",
               {bus.ex_valid_o, bus.ex_branch_o, bus.ex_memread_o, bus.ex_memtoreg_o,
                bus.ex_memwrite_o, bus.ex_alusrc_o, bus.ex_regwrite_o});
    else pass_cnt++;
    total_cnt++;
    if (bus.ex_aluop_o !== 4'd0 || bus.ex_pc_o !== 32'd0 || bus.ex_rs1_data_o !== 32'd0 ||
        bus.ex_rs2_data_o !== 32'd0 || bus.ex_imm_o !== 32'd0)
      $display("FAIL reset_data aluop=%h pc=%h rs1d=%h rs2d=%h imm=%h required all 0",
               bus.ex_aluop_o, bus.ex_pc_o, bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_imm_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.ex_rs1_o !== 5'd0 || bus.ex_rs2_o !== 5'd0 || bus.ex_rd_o !== 5'd0 ||
        bus.bubble_cnt_o !== 16'd0 || bus.flush_cnt_o !== 16'd0)
      $display("FAIL reset_regs_cnt rs1=%0d rs2=%0d rd=%0d bub=%0d fl=%0d required all 0",
               bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o, bus.bubble_cnt_o, bus.flush_cnt_o);
    else pass_cnt++;
    tick();
    rst_ni = 1'b1;
    clear_id();
  endtask

  task automatic test_plain_load();
    clear_id();
    bus.id_valid_i    = 1'b1;
    bus.id_regwrite_i = 1'b1;
    bus.id_aluop_i    = 4'b0010;
    bus.id_rd_i       = 5'd5;
    bus.id_rs1_data_i = 32'h1234;
    #1;
    total_cnt++;
    if (bus.id_stall_o !== 1'b0) $display("FAIL plain_stall got %b required 0", bus.id_stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_regwrite_o !== 1'b1 || bus.ex_aluop_o !== 4'd2 ||
        bus.ex_rd_o !== 5'd5 || bus.ex_rs1_data_o !== 32'h1234)
      $display("FAIL plain_load v=%b rw=%b aluop=%0d rd=%0d rs1d=%h required 1 1 2 5 1234",
               bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_aluop_o, bus.ex_rd_o,
               bus.ex_rs1_data_o);
    else pass_cnt++;
    // Invalid slot: controls must be forced to 0 even though inputs are set.
    bus.id_valid_i    = 1'b0;
    bus.id_memwrite_i = 1'b1;
    tick();
    total_cnt++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_regwrite_o !== 1'b0 || bus.ex_memwrite_o !== 1'b0)
      $display("FAIL invalid_ctrl v=%b rw=%b mw=%b required 0 0 0",
               bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_memwrite_o);
    else pass_cnt++;
  endtask

  task automatic set_add(input logic [4:0] rs2, input logic uses_rs2);
    clear_id();
    bus.id_valid_i    = 1'b1;
    bus.id_regwrite_i = 1'b1;
    bus.id_rs1_i      = 5'd1;
    bus.id_uses_rs1_i = 1'b1;
    bus.id_rs2_i      = rs2;
    bus.id_uses_rs2_i = uses_rs2;
    bus.id_rd_i       = 5'd8;
    bus.id_pc_i       = 32'h40;
  endtask

  task automatic test_load_use();
    load_lw(5'd7);
    set_add(5'd7, 1'b1);
    #1;
    total_cnt++;
    if (bus.id_stall_o !== 1'b1) $display("FAIL lu_stall got %b required 1", bus.id_stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_rd_o !== 5'd0 || bus.ex_memread_o !== 1'b0 ||
        bus.ex_regwrite_o !== 1'b0 || bus.bubble_cnt_o !== 16'd1)
      $display("FAIL lu_bubble v=%b rd=%0d mr=%b rw=%b bub=%0d required 0 0 0 0 1",
               bus.ex_valid_o, bus.ex_rd_o, bus.ex_memread_o, bus.ex_regwrite_o,
               bus.bubble_cnt_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.id_stall_o !== 1'b0) $display("FAIL lu_unstall got %b required 0", bus.id_stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd8 || bus.ex_rs2_o !== 5'd7 ||
        bus.ex_pc_o !== 32'h40 || bus.bubble_cnt_o !== 16'd1)
      $display("FAIL lu_release v=%b rd=%0d rs2=%0d pc=%h bub=%0d required 1 8 7 40 1",
               bus.ex_valid_o, bus.ex_rd_o, bus.ex_rs2_o, bus.ex_pc_o, bus.bubble_cnt_o);
    else pass_cnt++;
    // Destination x0 never stalls.
    load_lw(5'd0);
    set_add(5'd0, 1'b1);
    #1;
    total_cnt++;
    if (bus.id_stall_o !== 1'b0) $display("FAIL x0_stall got %b required 0", bus.id_stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd8 || bus.bubble_cnt_o !== 16'd1)
      $display("FAIL x0_load v=%b rd=%0d bub=%0d required 1 8 1",
               bus.ex_valid_o, bus.ex_rd_o, bus.bubble_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_no_false_hazard();
    load_lw(5'd7);
    set_add(5'd7, 1'b0);
    bus.id_rs1_i = 5'd3;
    #1;
    total_cnt++;
    if (bus.id_stall_o !== 1'b0) $display("FAIL nofalse_stall got %b required 0", bus.id_stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd8 || bus.bubble_cnt_o !== 16'd1)
      $display("FAIL nofalse_load v=%b rd=%0d bub=%0d required 1 8 1",
               bus.ex_valid_o, bus.ex_rd_o, bus.bubble_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_flush_priority();
    load_lw(5'd7);
    set_add(5'd7, 1'b1);
    bus.flush_i   = 1'b1;
    bus.ex_hold_i = 1'b1;
    #1;
    total_cnt++;
    if (bus.id_stall_o !== 1'b0) $display("FAIL flush_stall got %b required 0", bus.id_stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_rd_o !== 5'd0 || bus.ex_memread_o !== 1'b0 ||
        bus.flush_cnt_o !== 16'd1 || bus.bubble_cnt_o !== 16'd1)
      $display("FAIL flush_prio v=%b rd=%0d mr=%b fl=%0d bub=%0d required 0 0 0 1 1",
               bus.ex_valid_o, bus.ex_rd_o, bus.ex_memread_o, bus.flush_cnt_o,
               bus.bubble_cnt_o);
    else pass_cnt++;
    clear_id();
  endtask

  task automatic test_hold();
    clear_id();
    bus.id_valid_i    = 1'b1;
    bus.id_alusrc_i   = 1'b1;
    bus.id_regwrite_i = 1'b1;
    bus.id_aluop_i    = 4'd5;
    bus.id_pc_i       = 32'h100;
    bus.id_imm_i      = 32'h55;
    bus.id_rd_i       = 5'd12;
    tick();
    bus.ex_hold_i  = 1'b1;
    bus.id_pc_i    = 32'h104;
    bus.id_aluop_i = 4'd9;
    bus.id_rd_i    = 5'd13;
    bus.id_imm_i   = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (bus.id_stall_o !== 1'b1)
        $display("FAIL hold_stall[%0d] got %b required 1", i, bus.id_stall_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.ex_valid_o !== 1'b1 || bus.ex_pc_o !== 32'h100 || bus.ex_aluop_o !== 4'd5 ||
          bus.ex_rd_o !== 5'd12 || bus.ex_imm_o !== 32'h55)
        $display("FAIL hold_frozen[%0d] v=%b pc=%h aluop=%0d rd=%0d imm=%h required 1 100 5 12 55",
                 i, bus.ex_valid_o, bus.ex_pc_o, bus.ex_aluop_o, bus.ex_rd_o, bus.ex_imm_o);
      else pass_cnt++;
    end
    bus.ex_hold_i = 1'b0;
    tick();
    total_cnt++;
    if (bus.ex_pc_o !== 32'h104 || bus.ex_aluop_o !== 4'd9 || bus.ex_rd_o !== 5'd13)
      $display("FAIL hold_release pc=%h aluop=%0d rd=%0d required 104 9 13",
               bus.ex_pc_o, bus.ex_aluop_o, bus.ex_rd_o);
    else pass_cnt++;
    clear_id();
  endtask

  task automatic test_saturation();
    do_reset();
    clear_id();
    bus.flush_i = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk_i);
    #1;
    total_cnt++;
    if (bus.flush_cnt_o !== 16'hFFFE)
      $display("FAIL sat_pre got %h required fffe", bus.flush_cnt_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) @(posedge clk_i);
    #1;
    total_cnt++;
    if (bus.flush_cnt_o !== 16'hFFFF || bus.bubble_cnt_o !== 16'd0)
      $display("FAIL sat_flush fl=%h bub=%h required ffff 0", bus.flush_cnt_o, bus.bubble_cnt_o);
    else pass_cnt++;
    bus.flush_i = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_ni    = 1'b0;
    clear_id();
    tick();
    rst_ni = 1'b1;
    test_reset();
    test_plain_load();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_hold();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode stage (control unit plus register-file read) and the execute stage of the segmented RV32I core.
- Captures the decoded control bundle, operands, immediate and register addresses once per cycle.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles.
- Applies branch flushes and honours an EX-side hold. Keeps saturating bubble and flush counters for performance debug.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- id_valid_i  in  1  decode holds a real instruction.
- id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i, id_alusrc_i, id_regwrite_i  in  1 each  control bits from decode.
- id_aluop_i  in  4  ALU operation code from decode.
- id_pc_i  in  XLEN  PC of the decode instruction.
- id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN  operands and immediate.
- id_rs1_i, id_rs2_i, id_rd_i  in  5  register addresses.
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  instruction actually reads rs1/rs2.
- flush_i  in  1  branch taken in EX; kill the decode instruction.
- ex_hold_i  in  1  EX cannot accept a new instruction this cycle.
- ex_valid_o  out  1  EX register holds a real instruction.
- ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o, ex_alusrc_o, ex_regwrite_o  out  1 each  registered control bits.
- ex_aluop_o  out  4  registered ALU operation code.
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN  registered datapath values.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5  registered register addresses.
- id_stall_o  out  1  combinational; IF/ID and PC must hold this cycle.
- bubble_cnt_o, flush_cnt_o  out  CNT_W  performance counters.

Behaviour:
- Reset (asynchronous, rst_ni=0): every registered output goes to 0, including ex_valid_o, all control bits, ex_aluop_o=4'b0000, datapath fields and both counters. Reset asserted mid-operation discards the in-flight instruction immediately.
- Latency: 1 cycle from the id_* inputs to the ex_* outputs when loaded.
- Hazard term: hz = ex_valid_o & ex_memread_o & (ex_rd_o != 0) & ((id_uses_rs1_i & id_rs1_i == ex_rd_o) | (id_uses_rs2_i & id_rs2_i == ex_rd_o)) & id_valid_i.
- id_stall_o = ~flush_i & (hz | ex_hold_i).
- Per-edge action, first matching rule wins:
  1. flush_i=1: load a bubble; flush_cnt increments.
  2. ex_hold_i=1: all EX registers hold their values.
  3. hz=1: load a bubble; bubble_cnt increments.
  4. Otherwise: load the id_* inputs; ex_valid_o <= id_valid_i.
- Bubble definition: ex_valid_o=0, all six control bits 0, ex_aluop_o=0, ex_rd_o=0. Datapath fields are don't-care but must be deterministic (load zero).
- When id_valid_i=0 and the load rule applies, the control bits are still forced to 0 and no architectural state can change downstream.
- Counters saturate at all-ones and never wrap; they reset only through rst_ni.
- A load-use hazard lasts exactly one bubble cycle: after the bubble, ex_valid_o=0, so hz deasserts and the stalled instruction loads on the next edge.
- The hazard is never raised for rd=x0.
- flush_i together with ex_hold_i: the flush wins and the bubble is loaded.
- flush_i together with hz: the flush wins, id_stall_o=0, and only flush_cnt increments.
- No internal multi-cycle state beyond the registers and counters. Hazard evaluation uses only current register contents plus the id_* inputs.

Test Plan:
- Reset: drive every id_* input to nonzero values, pulse rst_ni low between clock edges -> all outputs read 0 asynchronously, ex_valid_o=0, counters 0.
- Plain load: id_valid_i=1, regwrite=1, aluop=4'b0010, rd=5, rs1_data=32'h1234 -> next cycle ex_regwrite_o=1, ex_aluop_o=2, ex_rd_o=5, ex_rs1_data_o=32'h1234, id_stall_o=0.
- Load-use: EX holds lw with rd=7; ID holds add with rs2=7, uses_rs2=1 -> id_stall_o=1 for one cycle; one bubble loads; bubble_cnt_o=1; add enters EX on the following edge. Repeat with rd=0 -> no stall.
- No false hazard: EX holds lw rd=7; ID instruction has rs2=7 but uses_rs2=0 -> no stall, bubble_cnt_o unchanged.
- Flush priority: flush_i=1 with ex_hold_i=1 and an active hazard -> bubble loaded, id_stall_o=0, flush_cnt_o=1, bubble_cnt_o unchanged.
- Hold and saturation: ex_hold_i=1 for 3 cycles -> EX outputs frozen and id_stall_o=1 throughout. Drive 2^CNT_W+2 flushes -> flush_cnt_o stays at 16'hFFFF.
